// File: rtl/t6d_mask_pkg.sv
// Shared types and helpers for the row mask tiler.
package t6d_mask_pkg;

  typedef enum logic [1:0] {
    TL_IDLE,
    TL_EMIT
  } tiler_state_t;

  localparam int MASK_WORD_W = 32;

  typedef logic [0:MASK_WORD_W-1] mask_word_t;

  // A zero tile period stands for a full 32-pixel tile.
  function automatic logic [5:0] decode_pw(input logic [4:0] pw);
    return (pw == 5'd0) ? 6'd32 : {1'b0, pw};
  endfunction

endpackage

// File: rtl/row_tile_expander.sv
// Combinational expander: builds one 32-pixel mask word from a tiled row
// pattern, starting at a given phase, and reports the phase for the next word.
module row_tile_expander
  import t6d_mask_pkg::*;
(
  input  mask_word_t  pattern_i,
  input  logic [5:0]  pw_i,
  input  logic [4:0]  phase_i,
  input  logic [5:0]  valid_pixels_i,
  output mask_word_t  mask_word_o,
  output logic [4:0]  next_phase_o
);

  logic [5:0] idx;
  logic [5:0] idx_inc;

  // Walk the tile one pixel at a time with a wrap-increment instead of a modulo,
  // blanking pixels that lie beyond the row width.
  always_comb begin
    mask_word_o = '0;
    idx         = {1'b0, phase_i};
    idx_inc     = '0;
    for (int k = 0; k < MASK_WORD_W; k++) begin
      if (6'(k) < valid_pixels_i) begin
        mask_word_o[k] = pattern_i[idx[4:0]];
      end
      idx_inc = idx + 6'd1;
      idx     = (idx_inc == pw_i) ? 6'd0 : idx_inc;
    end
    next_phase_o = idx[4:0];
  end

endmodule

// File: rtl/row_mask_tiler.sv
// Row mask tiler: accepts one row pattern from the repeat-pattern scheduler,
// tiles it across the sensor row and streams it out as 32-pixel mask words.
module row_mask_tiler
  import t6d_mask_pkg::*;
#(
  parameter int MAX_W = 1920,
  parameter int MAX_H = 1080,
  parameter int OUT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        frame_sync,
  input  logic [10:0] image_sensor_w,
  input  logic [10:0] image_sensor_h,
  input  logic [4:0]  pattern_w,
  input  logic        load_pattern,
  input  logic [0:31] pattern,
  output logic        rp_valid,
  output logic [0:31] mask_word,
  output logic        mask_valid,
  input  logic        mask_ready,
  output logic        mask_last_word,
  output logic        mask_last_row
);

  localparam int WCW = $clog2((MAX_W + OUT_W - 1) / OUT_W + 1);
  localparam int RCW = $clog2(MAX_H + 1);

  tiler_state_t   state_q, state_d;
  mask_word_t     pattern_q, pattern_d;
  logic [5:0]     pw_q, pw_d;
  logic [10:0]    w_eff_q, w_eff_d;
  logic [WCW-1:0] words_q, words_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [RCW-1:0] h_eff_q, h_eff_d;
  logic [RCW-1:0] row_cnt_q, row_cnt_d;
  logic [4:0]     phase_q, phase_d;
  logic           rp_valid_q, rp_valid_d;

  logic [10:0]    w_in_eff;
  logic [RCW-1:0] h_in_eff;
  logic [WCW-1:0] words_in;
  logic [10:0]    remaining;
  logic [5:0]     valid_pixels;
  mask_word_t     tile_word;
  logic [4:0]     next_phase;
  logic           accept;
  logic           xfer;
  logic           last_word;
  logic           last_row;

  // Out-of-range or zero geometry falls back to the full sensor size.
  assign w_in_eff = (image_sensor_w == 11'd0 || int'(image_sensor_w) > MAX_W)
                    ? 11'(MAX_W) : image_sensor_w;
  assign h_in_eff = (image_sensor_h == 11'd0 || int'(image_sensor_h) > MAX_H)
                    ? RCW'(MAX_H) : RCW'(image_sensor_h);
  assign words_in = WCW'((int'(w_in_eff) + OUT_W - 1) / OUT_W);

  assign remaining    = w_eff_q - 11'(int'(word_cnt_q) * OUT_W);
  assign valid_pixels = (int'(remaining) >= OUT_W) ? 6'(OUT_W) : remaining[5:0];

  assign last_word = (word_cnt_q == words_q - WCW'(1));
  assign last_row  = (row_cnt_q == h_eff_q - RCW'(1));
  assign accept    = (state_q == TL_IDLE) && rp_valid_q && load_pattern;
  assign xfer      = (state_q == TL_EMIT) && mask_ready;

  row_tile_expander u_expander (
    .pattern_i      (pattern_q),
    .pw_i           (pw_q),
    .phase_i        (phase_q),
    .valid_pixels_i (valid_pixels),
    .mask_word_o    (tile_word),
    .next_phase_o   (next_phase)
  );

  assign mask_valid     = (state_q == TL_EMIT);
  assign mask_word      = mask_valid ? tile_word : '0;
  assign mask_last_word = mask_valid && last_word;
  assign mask_last_row  = mask_valid && last_row;
  assign rp_valid       = rp_valid_q;

  // Next-state logic: frame_sync aborts everything, otherwise load a row in IDLE
  // and advance one word per accepted transfer in EMIT.
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    pw_d       = pw_q;
    w_eff_d    = w_eff_q;
    words_d    = words_q;
    h_eff_d    = h_eff_q;
    word_cnt_d = word_cnt_q;
    row_cnt_d  = row_cnt_q;
    phase_d    = phase_q;
    rp_valid_d = rp_valid_q;

    if (frame_sync) begin
      state_d    = TL_IDLE;
      row_cnt_d  = '0;
      word_cnt_d = '0;
      phase_d    = '0;
      rp_valid_d = 1'b1;
    end else begin
      unique case (state_q)
        TL_IDLE: begin
          rp_valid_d = 1'b1;
          if (accept) begin
            pattern_d  = pattern;
            pw_d       = decode_pw(pattern_w);
            w_eff_d    = w_in_eff;
            words_d    = words_in;
            h_eff_d    = h_in_eff;
            word_cnt_d = '0;
            phase_d    = '0;
            rp_valid_d = 1'b0;
            state_d    = TL_EMIT;
          end
        end
        TL_EMIT: begin
          rp_valid_d = 1'b0;
          if (xfer) begin
            if (last_word) begin
              state_d   = TL_IDLE;
              row_cnt_d = last_row ? '0 : row_cnt_q + RCW'(1);
            end else begin
              word_cnt_d = word_cnt_q + WCW'(1);
              phase_d    = next_phase;
            end
          end
        end
        default: begin
          state_d = TL_IDLE;
        end
      endcase
    end
  end

  // State registers; clk_en low freezes the whole block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TL_IDLE;
      pattern_q  <= '0;
      pw_q       <= 6'd32;
      w_eff_q    <= '0;
      words_q    <= '0;
      h_eff_q    <= '0;
      word_cnt_q <= '0;
      row_cnt_q  <= '0;
      phase_q    <= '0;
      rp_valid_q <= 1'b0;
    end else if (clk_en) begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      pw_q       <= pw_d;
      w_eff_q    <= w_eff_d;
      words_q    <= words_d;
      h_eff_q    <= h_eff_d;
      word_cnt_q <= word_cnt_d;
      row_cnt_q  <= row_cnt_d;
      phase_q    <= phase_d;
      rp_valid_q <= rp_valid_d;
    end
  end

endmodule
